// File: rtl/snoopy_bus_master.sv
// ============================================================================
// Module   : snoopy_bus_master
// Brief    : Bus-side request engine of a snoopy cache: arbitrates, issues
//            BUS_READ / BUS_READ_EXCLUSIVE / BUS_INVALIDATE, fills the block
//            word by word and writes the final MSI state.
// Options  : SNOOPY_BUS_MASTER_CRITICAL_WORD_FIRST_EN (fill starts at the
//            requested word offset instead of word 0)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoopy_bus_master #(
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      missReq,
    input  logic                                      missExclusive,
    input  logic                                      upgradeReq,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] reqAddress,
    output logic                                      missDone,
    output logic                                      busRequest,
    input  logic                                      busGrant,
    output logic [1:0]                                commandOut,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
    output logic                                      busReadEnabled,
    input  logic                                      busFunctionComplete,
    input  logic [DATA_WIDTH-1:0]                     busDataIn,
    output logic                                      fillWrite,
    output logic [OFFSET_WIDTH-1:0]                   fillOffset,
    output logic [DATA_WIDTH-1:0]                     fillData,
    output logic                                      fillStateWrite,
    output logic [1:0]                                fillState
);

    localparam int unsigned ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
    localparam int unsigned BLOCK_WIDTH = TAG_WIDTH + INDEX_WIDTH;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_RDX   = 2'd2;
    localparam logic [1:0] CMD_INV   = 2'd3;

    localparam logic [1:0] MSI_SHARED   = 2'd1;
    localparam logic [1:0] MSI_MODIFIED = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_READ  = 3'd2,
        S_INV   = 3'd3,
        S_STATE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [BLOCK_WIDTH-1:0]  block_q, block_d;
    logic [OFFSET_WIDTH-1:0] wordCounter_q, wordCounter_d;
    logic                    fillWrite_q;
    logic [OFFSET_WIDTH-1:0] fillOffset_q;
    logic [DATA_WIDTH-1:0]   fillData_q;
    logic                    lastFill_q;

    logic [OFFSET_WIDTH-1:0] startOffset;
    logic [OFFSET_WIDTH-1:0] wordNext;
    logic                    wordFire;
    logic                    wordLast;

`ifdef SNOOPY_BUS_MASTER_CRITICAL_WORD_FIRST_EN
    logic [OFFSET_WIDTH-1:0] startOffset_q, startOffset_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            startOffset_q <= '0;
        end else begin
            startOffset_q <= startOffset_d;
        end
    end

    always_comb begin
        startOffset_d = startOffset_q;
        if (state_q == S_IDLE && missReq) begin
            startOffset_d = reqAddress[OFFSET_WIDTH-1:0];
        end
    end

    assign startOffset = startOffset_q;
`else
    logic unusedReqOffset;

    assign unusedReqOffset = ^reqAddress[OFFSET_WIDTH-1:0];
    assign startOffset     = '0;
`endif

    // lastFill_q marks the cycle the final word is being written; the bus is
    // no longer read then and the FSM moves on to the state write.
    assign wordFire = (state_q == S_READ) && busGrant && busFunctionComplete && !lastFill_q;
    assign wordNext = wordCounter_q + OFFSET_WIDTH'(1);
    assign wordLast = (wordNext == startOffset);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_NONE;
            block_q       <= '0;
            wordCounter_q <= '0;
            fillWrite_q   <= 1'b0;
            fillOffset_q  <= '0;
            fillData_q    <= '0;
            lastFill_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            block_q       <= block_d;
            wordCounter_q <= wordCounter_d;
            fillWrite_q   <= wordFire;
            fillOffset_q  <= wordFire ? wordCounter_q : '0;
            fillData_q    <= wordFire ? busDataIn : '0;
            lastFill_q    <= wordFire && wordLast;
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        block_d        = block_q;
        wordCounter_d  = wordCounter_q;
        busRequest     = 1'b0;
        commandOut     = CMD_NONE;
        busAddress     = '0;
        busReadEnabled = 1'b0;
        fillStateWrite = 1'b0;
        fillState      = 2'd0;
        missDone       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (missReq) begin
                    cmd_d   = missExclusive ? CMD_RDX : CMD_READ;
                    block_d = reqAddress[ADDR_WIDTH-1:OFFSET_WIDTH];
`ifdef SNOOPY_BUS_MASTER_CRITICAL_WORD_FIRST_EN
                    wordCounter_d = reqAddress[OFFSET_WIDTH-1:0];
`else
                    wordCounter_d = '0;
`endif
                    state_d = S_ARB;
                end else if (upgradeReq) begin
                    cmd_d         = CMD_INV;
                    block_d       = reqAddress[ADDR_WIDTH-1:OFFSET_WIDTH];
                    wordCounter_d = '0;
                    state_d       = S_ARB;
                end
            end
            S_ARB: begin
                busRequest = 1'b1;
                commandOut = cmd_q;
                busAddress = {block_q, wordCounter_q};
                if (busGrant) begin
                    state_d = (cmd_q == CMD_INV) ? S_INV : S_READ;
                end
            end
            S_READ: begin
                busRequest     = 1'b1;
                commandOut     = cmd_q;
                busAddress     = {block_q, wordCounter_q};
                busReadEnabled = busGrant && !lastFill_q;
                if (wordFire) begin
                    wordCounter_d = wordNext;
                end
                if (lastFill_q) begin
                    state_d = S_STATE;
                end
            end
            S_INV: begin
                busRequest = 1'b1;
                commandOut = cmd_q;
                busAddress = {block_q, wordCounter_q};
                state_d    = S_STATE;
            end
            S_STATE: begin
                busRequest     = 1'b1;
                fillStateWrite = 1'b1;
                fillState      = (cmd_q == CMD_READ) ? MSI_SHARED : MSI_MODIFIED;
                state_d        = S_DONE;
            end
            S_DONE: begin
                missDone = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fillWrite  = fillWrite_q;
    assign fillOffset = fillOffset_q;
    assign fillData   = fillData_q;

endmodule

`default_nettype wire

// File: tb/tb_snoopy_bus_master.sv
// ============================================================================
// Module   : tb_snoopy_bus_master
// Brief    : Directed self-checking bench for snoopy_bus_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snoopy_bus_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        missReq;
    logic        missExclusive;
    logic        upgradeReq;
    logic [15:0] reqAddress;
    logic        missDone;
    logic        busRequest;
    logic        busGrant;
    logic [1:0]  commandOut;
    logic [15:0] busAddress;
    logic        busReadEnabled;
    logic        busFunctionComplete;
    logic [31:0] busDataIn;
    logic        fillWrite;
    logic [3:0]  fillOffset;
    logic [31:0] fillData;
    logic        fillStateWrite;
    logic [1:0]  fillState;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    // Responders echo the bus address so each fill word is identifiable.
    assign busDataIn = {16'hDA7A, busAddress};

    snoopy_bus_master dut (
        .clock               (clock),
        .reset               (reset),
        .missReq             (missReq),
        .missExclusive       (missExclusive),
        .upgradeReq          (upgradeReq),
        .reqAddress          (reqAddress),
        .missDone            (missDone),
        .busRequest          (busRequest),
        .busGrant            (busGrant),
        .commandOut          (commandOut),
        .busAddress          (busAddress),
        .busReadEnabled      (busReadEnabled),
        .busFunctionComplete (busFunctionComplete),
        .busDataIn           (busDataIn),
        .fillWrite           (fillWrite),
        .fillOffset          (fillOffset),
        .fillData            (fillData),
        .fillStateWrite      (fillStateWrite),
        .fillState           (fillState)
    );

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, {busRequest, commandOut, busReadEnabled, fillWrite, fillStateWrite,
                          fillState, missDone, busAddress, fillOffset, fillData}, 64'd0);
    endtask

    function automatic logic [3:0] start_of(input logic [15:0] addr);
`ifdef SNOOPY_BUS_MASTER_CRITICAL_WORD_FIRST_EN
        return addr[3:0];
`else
        return (addr[0] === 1'bx) ? 4'd0 : 4'd0;
`endif
    endfunction

    // Cycle t0 is the cycle the request is first presented; inputs for a cycle
    // are applied 1 time unit after its rising edge, outputs are sampled 1 later.
    task automatic run_txn(input logic [15:0] addr, input logic excl, input logic upg,
                           input int grantFrom, input int gapStart, input int gapLen,
                           input int expDone, input int expFills,
                           input logic [1:0] expCmd, input logic [1:0] expState);
        int         fills;
        bit         done;
        logic [3:0] start;
        logic [3:0] expOff;
        fills = 0;
        done  = 1'b0;
        start = upg ? 4'd0 : start_of(addr);
        @(posedge clock); #1;
        missReq             = !upg;
        missExclusive       = excl;
        upgradeReq          = upg;
        reqAddress          = addr;
        busGrant            = (grantFrom <= 0);
        busFunctionComplete = 1'b1;
        for (int c = 1; c < 100 && !done; c++) begin
            @(posedge clock); #1;
            busGrant = (c >= grantFrom) && !(c >= gapStart && c < gapStart + gapLen);
            #1;
            if (c == 1) begin
                check_value("arb_request", busRequest, 1);
                check_value("arb_command", commandOut, expCmd);
                check_value("arb_address", busAddress, {addr[15:4], start});
            end
            if (c >= gapStart && c < gapStart + gapLen)
                check_value("gap_read_enable", busReadEnabled, 0);
            if (upg && c == expDone - 2)
                check_value("inv_command", commandOut, 3);
            if (fillWrite) begin
                expOff = start + 4'(fills);
                check_value("fill_offset", fillOffset, expOff);
                check_value("fill_data", fillData, {16'hDA7A, addr[15:4], expOff});
                fills++;
            end
            if (fillStateWrite) begin
                check_value("state_write_cycle", c, expDone - 1);
                check_value("fill_state", fillState, expState);
                if (upg) check_value("inv_cmd_released", commandOut, 0);
            end
            if (missDone) begin
                check_value("done_cycle", c, expDone);
                check_value("fill_count", fills, expFills);
                done       = 1'b1;
                missReq    = 1'b0;
                upgradeReq = 1'b0;
                busGrant   = 1'b0;
            end
        end
        if (!done) begin
            check_value("txn_timeout", 1, 0);
            missReq    = 1'b0;
            upgradeReq = 1'b0;
            busGrant   = 1'b0;
        end
    endtask

    initial begin
        bit stray;
        reset               = 1'b1;
        missReq             = 1'b0;
        missExclusive       = 1'b0;
        upgradeReq          = 1'b0;
        reqAddress          = '0;
        busGrant            = 1'b0;
        busFunctionComplete = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check_all_zero("reset_outputs");
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_all_zero("idle_outputs");

        // Plain read, immediate grant, completion every cycle.
        run_txn(16'h1235, 1'b0, 1'b0, 0, 1000, 0, 20, 16, 2'd1, 2'd1);
        // Exclusive read.
        run_txn(16'hA7C0, 1'b1, 1'b0, 0, 1000, 0, 20, 16, 2'd2, 2'd2);
        // Upgrade, grant arrives at t3.
        run_txn(16'h5E30, 1'b0, 1'b1, 3, 1000, 0, 6, 0, 2'd3, 2'd2);
        // Grant withdrawn for three cycles right after word 7 completes.
        run_txn(16'h3C40, 1'b0, 1'b0, 0, 10, 3, 23, 16, 2'd1, 2'd1);
        // Critical-word-first ordering (or plain 0..15 when disabled).
        run_txn(16'h77DD, 1'b1, 1'b0, 0, 1000, 0, 20, 16, 2'd2, 2'd2);

        // Reset in the cycle after word 4 completes.
        @(posedge clock); #1;
        missReq             = 1'b1;
        missExclusive       = 1'b0;
        reqAddress          = 16'h4B20;
        busGrant            = 1'b1;
        busFunctionComplete = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clock); #1;
            if (c == 7) reset = 1'b1;
        end
        @(posedge clock); #1;
        reset    = 1'b0;
        missReq  = 1'b0;
        busGrant = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #2;
            if (fillStateWrite || missDone || fillWrite || busRequest) stray = 1'b1;
        end
        check_value("abort_no_activity", stray, 0);
        run_txn(16'h4B20, 1'b0, 1'b0, 0, 1000, 0, 20, 16, 2'd1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
